// File: rtl/branch_resolve_unit_if.sv
// Control-transfer handshake, PC and statistics bus between the control FSM
// and branch_resolve_unit.
interface branch_resolve_unit_if;
  logic        req;
  logic [1:0]  xfer_kind;
  logic        br_en;
  logic [31:0] imm;
  logic [31:0] rs1_out;
  logic        pc_inc;
  logic        stat_clr;
  logic        ready;
  logic        done;
  logic        taken;
  logic        misalign;
  logic [31:0] pc_out;
  logic [31:0] link_addr;
  logic [31:0] branch_cnt;
  logic [31:0] taken_cnt;

  modport master (
    output req, xfer_kind, br_en, imm, rs1_out, pc_inc, stat_clr,
    input  ready, done, taken, misalign, pc_out, link_addr, branch_cnt, taken_cnt
  );

  modport slave (
    input  req, xfer_kind, br_en, imm, rs1_out, pc_inc, stat_clr,
    output ready, done, taken, misalign, pc_out, link_addr, branch_cnt, taken_cnt
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// Architectural PC owner for the RV32I multicycle datapath: resolves BR/JAL/JALR
// targets through an IDLE/EVAL/COMMIT handshake and keeps saturating branch stats.
module branch_resolve_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0060
) (
  input  logic                  clk,
  input  logic                  rst,
  branch_resolve_unit_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EVAL   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [1:0] KIND_BR   = 2'b00;
  localparam logic [1:0] KIND_JALR = 2'b10;
  localparam logic [1:0] KIND_RSVD = 2'b11;

  state_t      state_q, state_d;
  logic [1:0]  kind_q, kind_d;
  logic        br_en_q, br_en_d;
  logic [31:0] imm_q, imm_d;
  logic [31:0] rs1_q, rs1_d;
  logic [31:0] base_q, base_d;
  logic [31:0] link_q, link_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] target_q, target_d;
  logic        redirect_q, redirect_d;
  logic        misalign_q, misalign_d;
  logic [31:0] branch_cnt_q, branch_cnt_d;
  logic [31:0] taken_cnt_q, taken_cnt_d;
  logic        commit_taken;
  logic        count_br;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      kind_q       <= '0;
      br_en_q      <= 1'b0;
      imm_q        <= '0;
      rs1_q        <= '0;
      base_q       <= '0;
      link_q       <= '0;
      pc_q         <= RESET_PC;
      target_q     <= '0;
      redirect_q   <= 1'b0;
      misalign_q   <= 1'b0;
      branch_cnt_q <= '0;
      taken_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      kind_q       <= kind_d;
      br_en_q      <= br_en_d;
      imm_q        <= imm_d;
      rs1_q        <= rs1_d;
      base_q       <= base_d;
      link_q       <= link_d;
      pc_q         <= pc_d;
      target_q     <= target_d;
      redirect_q   <= redirect_d;
      misalign_q   <= misalign_d;
      branch_cnt_q <= branch_cnt_d;
      taken_cnt_q  <= taken_cnt_d;
    end
  end

  assign commit_taken = redirect_q & ~misalign_q;
  assign count_br     = (state_q == COMMIT) && (kind_q == KIND_BR);

  always_comb begin
    state_d    = state_q;
    kind_d     = kind_q;
    br_en_d    = br_en_q;
    imm_d      = imm_q;
    rs1_d      = rs1_q;
    base_d     = base_q;
    link_d     = link_q;
    pc_d       = pc_q;
    target_d   = target_q;
    redirect_d = redirect_q;
    misalign_d = misalign_q;

    case (state_q)
      IDLE: begin
        if (bus.req) begin
          kind_d  = bus.xfer_kind;
          br_en_d = bus.br_en;
          imm_d   = bus.imm;
          rs1_d   = bus.rs1_out;
          base_d  = pc_q;
          link_d  = pc_q + 32'd4;
          state_d = EVAL;
        end else if (bus.pc_inc) begin
          pc_d = pc_q + 32'd4;
        end
      end
      EVAL: begin
        if (kind_q == KIND_JALR) begin
          target_d = (rs1_q + imm_q) & ~32'h1;
        end else begin
          target_d = base_q + imm_q;
        end
        if (kind_q == KIND_BR) begin
          redirect_d = br_en_q;
        end else begin
          redirect_d = (kind_q != KIND_RSVD);
        end
        misalign_d = redirect_d & (target_d[1:0] != 2'b00);
        state_d    = COMMIT;
      end
      COMMIT: begin
        // A misaligned target leaves the PC on the faulting instruction.
        if (commit_taken) begin
          pc_d = target_q;
        end else if (!misalign_q) begin
          pc_d = base_q + 32'd4;
        end else begin
          pc_d = base_q;
        end
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    branch_cnt_d = branch_cnt_q;
    taken_cnt_d  = taken_cnt_q;
    if (bus.stat_clr) begin
      branch_cnt_d = '0;
      taken_cnt_d  = '0;
    end else if (count_br) begin
      if (branch_cnt_q != '1) begin
        branch_cnt_d = branch_cnt_q + 32'd1;
      end
      if (commit_taken && (taken_cnt_q != '1)) begin
        taken_cnt_d = taken_cnt_q + 32'd1;
      end
    end
  end

  assign bus.ready      = (state_q == IDLE);
  assign bus.done       = (state_q == COMMIT);
  assign bus.taken      = (state_q == COMMIT) & commit_taken;
  assign bus.misalign   = (state_q == COMMIT) & misalign_q;
  assign bus.pc_out     = pc_q;
  assign bus.link_addr  = link_q;
  assign bus.branch_cnt = branch_cnt_q;
  assign bus.taken_cnt  = taken_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Bench for branch_resolve_unit: directed scenarios plus randomized transfers
// checked against a transaction-level PC/counter model.
module tb_branch_resolve_unit;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  branch_resolve_unit_if bus ();

  branch_resolve_unit #(.RESET_PC(32'h0000_0060)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Transaction-level model state
  logic [31:0] pc_m, link_m, bcnt_m, tcnt_m;
  logic        exp_tk, exp_ms;
  // Observations captured during a transfer
  logic        o_ev_done, o_cm_done, o_cm_ready, o_tk, o_ms;

  task automatic model_reset();
    pc_m = 32'h60; link_m = '0; bcnt_m = '0; tcnt_m = '0;
  endtask

  task automatic model_apply(input logic [1:0] k, input logic b, input logic [31:0] im,
                             input logic [31:0] r, input logic clr);
    logic [31:0] tgt;
    logic        redir;
    link_m = pc_m + 4;
    case (k)
      2'd0:    begin tgt = pc_m + im; redir = b; end
      2'd1:    begin tgt = pc_m + im; redir = 1'b1; end
      2'd2:    begin tgt = r + im; tgt = tgt - (tgt % 2); redir = 1'b1; end
      default: begin tgt = pc_m + im; redir = 1'b0; end
    endcase
    exp_ms = redir && ((tgt % 4) != 0);
    exp_tk = redir && !exp_ms;
    if (exp_tk) pc_m = tgt;
    else if (!exp_ms) pc_m = pc_m + 4;
    if (clr) begin
      bcnt_m = 0; tcnt_m = 0;
    end else if (k == 2'd0) begin
      if (bcnt_m != 32'hFFFF_FFFF) bcnt_m = bcnt_m + 1;
      if (exp_tk && tcnt_m != 32'hFFFF_FFFF) tcnt_m = tcnt_m + 1;
    end
  endtask

  task automatic scramble();
    bus.req = 1'($urandom); bus.pc_inc = 1'($urandom); bus.xfer_kind = 2'($urandom);
    bus.br_en = 1'($urandom); bus.imm = $urandom; bus.rs1_out = $urandom;
  endtask

  task automatic run_xfer(input logic [1:0] k, input logic b, input logic [31:0] im,
                          input logic [31:0] r, input logic inc, input logic clr);
    @(negedge clk);
    bus.req = 1'b1; bus.xfer_kind = k; bus.br_en = b; bus.imm = im; bus.rs1_out = r;
    bus.pc_inc = inc; bus.stat_clr = 1'b0;
    @(posedge clk);
    @(negedge clk);
    o_ev_done = bus.done;
    scramble();
    @(posedge clk);
    @(negedge clk);
    o_cm_done = bus.done; o_cm_ready = bus.ready; o_tk = bus.taken; o_ms = bus.misalign;
    bus.stat_clr = clr;
    scramble();
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0; bus.pc_inc = 1'b0; bus.stat_clr = 1'b0;
    model_apply(k, b, im, r, clr);
  endtask

  task automatic setpc(input logic [31:0] t);
    run_xfer(2'b01, 1'b0, t - pc_m, 32'h0, 1'b0, 1'b0);
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (bus.pc_out !== 32'h60) begin errors++; $display("FAIL rst_pc: got %h exp %h", bus.pc_out, 32'h60); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b exp 1", bus.ready); end
    checks++; if ({bus.done, bus.taken, bus.misalign} !== 3'b000) begin errors++; $display("FAIL rst_flags: got %b exp 000", {bus.done, bus.taken, bus.misalign}); end
    checks++; if (bus.link_addr !== 32'h0) begin errors++; $display("FAIL rst_link: got %h exp 0", bus.link_addr); end
    // build some state, then abort a JAL mid-EVAL
    setpc(32'h300);
    run_xfer(2'b00, 1'b1, 32'h10, 32'h0, 1'b0, 1'b0);
    checks++; if (bus.branch_cnt !== 32'd1) begin errors++; $display("FAIL pre_rst_bcnt: got %0d exp 1", bus.branch_cnt); end
    @(negedge clk);
    bus.req = 1'b1; bus.xfer_kind = 2'b01; bus.imm = 32'h40;
    @(posedge clk);
    @(negedge clk);
    bus.req = 1'b0;
    rst = 1'b1;
    #1;
    checks++; if (bus.pc_out !== 32'h60) begin errors++; $display("FAIL midrst_pc: got %h exp %h", bus.pc_out, 32'h60); end
    checks++; if (bus.ready !== 1'b1) begin errors++; $display("FAIL midrst_ready: got %b exp 1", bus.ready); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL midrst_done: got %b exp 0", bus.done); end
    end
    rst = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    checks++; if (bus.done !== 1'b0) begin errors++; $display("FAIL postrst_done: got %b exp 0", bus.done); end
    checks++; if (bus.pc_out !== 32'h60) begin errors++; $display("FAIL postrst_pc: got %h exp %h", bus.pc_out, 32'h60); end
    checks++; if ({bus.branch_cnt, bus.taken_cnt} !== 64'h0) begin errors++; $display("FAIL postrst_cnt: got %h/%h exp 0/0", bus.branch_cnt, bus.taken_cnt); end
  endtask

  task automatic test_taken_beq();
    setpc(32'h100);
    run_xfer(2'b00, 1'b1, 32'hFFFF_FFF0, $urandom, 1'b0, 1'b0);
    checks++; if (o_ev_done !== 1'b0) begin errors++; $display("FAIL beq_eval_done: got %b exp 0", o_ev_done); end
    checks++; if ({o_cm_done, o_cm_ready, o_tk, o_ms} !== 4'b1010) begin errors++; $display("FAIL beq_commit: got %b exp 1010", {o_cm_done, o_cm_ready, o_tk, o_ms}); end
    checks++; if (bus.pc_out !== 32'hF0) begin errors++; $display("FAIL beq_pc: got %h exp %h", bus.pc_out, 32'hF0); end
    checks++; if ({bus.branch_cnt, bus.taken_cnt} !== {32'd1, 32'd1}) begin errors++; $display("FAIL beq_cnt: got %0d/%0d exp 1/1", bus.branch_cnt, bus.taken_cnt); end
  endtask

  task automatic test_not_taken_inc();
    setpc(32'h100);
    run_xfer(2'b00, 1'b0, 32'h40, $urandom, 1'b0, 1'b0);
    checks++; if ({o_cm_done, o_tk, o_ms} !== 3'b100) begin errors++; $display("FAIL nt_commit: got %b exp 100", {o_cm_done, o_tk, o_ms}); end
    checks++; if (bus.pc_out !== 32'h104) begin errors++; $display("FAIL nt_pc: got %h exp %h", bus.pc_out, 32'h104); end
    bus.pc_inc = 1'b1;
    @(posedge clk);
    #1;
    checks++; if (bus.pc_out !== 32'h108) begin errors++; $display("FAIL inc_one: got %h exp %h", bus.pc_out, 32'h108); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    bus.pc_inc = 1'b0;
    pc_m = pc_m + 12;
    checks++; if (bus.pc_out !== 32'h110) begin errors++; $display("FAIL inc_pc: got %h exp %h", bus.pc_out, 32'h110); end
    checks++; if ({bus.branch_cnt, bus.taken_cnt} !== {32'd2, 32'd1}) begin errors++; $display("FAIL nt_cnt: got %0d/%0d exp 2/1", bus.branch_cnt, bus.taken_cnt); end
  endtask

  task automatic test_jalr();
    setpc(32'h200);
    run_xfer(2'b10, 1'b0, 32'h0, 32'h1003, 1'b0, 1'b0);
    checks++; if ({o_cm_done, o_tk, o_ms} !== 3'b101) begin errors++; $display("FAIL jalr_mis_flags: got %b exp 101", {o_cm_done, o_tk, o_ms}); end
    checks++; if (bus.pc_out !== 32'h200) begin errors++; $display("FAIL jalr_mis_pc: got %h exp %h", bus.pc_out, 32'h200); end
    checks++; if (bus.link_addr !== 32'h204) begin errors++; $display("FAIL jalr_mis_link: got %h exp %h", bus.link_addr, 32'h204); end
    run_xfer(2'b10, 1'b0, 32'h0, 32'h1001, 1'b0, 1'b0);
    checks++; if ({o_tk, o_ms} !== 2'b10) begin errors++; $display("FAIL jalr_ok_flags: got %b exp 10", {o_tk, o_ms}); end
    checks++; if (bus.pc_out !== 32'h1000) begin errors++; $display("FAIL jalr_ok_pc: got %h exp %h", bus.pc_out, 32'h1000); end
    checks++; if ({bus.branch_cnt, bus.taken_cnt} !== {32'd2, 32'd1}) begin errors++; $display("FAIL jalr_cnt: got %0d/%0d exp 2/1", bus.branch_cnt, bus.taken_cnt); end
  endtask

  task automatic test_jal_wrap();
    setpc(32'hFFFF_FFF8);
    run_xfer(2'b01, 1'b0, 32'h10, $urandom, 1'b0, 1'b0);
    checks++; if (bus.pc_out !== 32'h8) begin errors++; $display("FAIL jal_wrap_pc: got %h exp %h", bus.pc_out, 32'h8); end
    checks++; if (bus.link_addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL jal_wrap_link: got %h exp %h", bus.link_addr, 32'hFFFF_FFFC); end
    checks++; if ({bus.branch_cnt, bus.taken_cnt} !== {32'd2, 32'd1}) begin errors++; $display("FAIL jal_cnt: got %0d/%0d exp 2/1", bus.branch_cnt, bus.taken_cnt); end
  endtask

  task automatic test_simultaneous();
    run_xfer(2'b00, 1'b1, 32'h20, $urandom, 1'b1, 1'b0);
    checks++; if (bus.pc_out !== 32'h28) begin errors++; $display("FAIL req_inc_pc: got %h exp %h", bus.pc_out, 32'h28); end
    checks++; if ({bus.branch_cnt, bus.taken_cnt} !== {32'd3, 32'd2}) begin errors++; $display("FAIL req_inc_cnt: got %0d/%0d exp 3/2", bus.branch_cnt, bus.taken_cnt); end
    run_xfer(2'b00, 1'b1, 32'h8, $urandom, 1'b0, 1'b1);
    checks++; if (bus.pc_out !== 32'h30) begin errors++; $display("FAIL clr_pc: got %h exp %h", bus.pc_out, 32'h30); end
    checks++; if ({bus.branch_cnt, bus.taken_cnt} !== 64'h0) begin errors++; $display("FAIL clr_cnt: got %0d/%0d exp 0/0", bus.branch_cnt, bus.taken_cnt); end
  endtask

  task automatic test_saturate();
    @(negedge clk);
    force dut.branch_cnt_q = 32'hFFFF_FFFF;
    force dut.taken_cnt_q  = 32'hFFFF_FFFF;
    #1;
    release dut.branch_cnt_q;
    release dut.taken_cnt_q;
    bcnt_m = 32'hFFFF_FFFF; tcnt_m = 32'hFFFF_FFFF;
    run_xfer(2'b00, 1'b1, 32'h40, $urandom, 1'b0, 1'b0);
    checks++; if ({bus.branch_cnt, bus.taken_cnt} !== {32'hFFFF_FFFF, 32'hFFFF_FFFF}) begin errors++; $display("FAIL sat_taken: got %h/%h exp ffffffff/ffffffff", bus.branch_cnt, bus.taken_cnt); end
    run_xfer(2'b00, 1'b0, 32'h40, $urandom, 1'b0, 1'b0);
    checks++; if (bus.branch_cnt !== 32'hFFFF_FFFF) begin errors++; $display("FAIL sat_nt: got %h exp ffffffff", bus.branch_cnt); end
    checks++; if (bus.pc_out !== pc_m) begin errors++; $display("FAIL sat_pc: got %h exp %h", bus.pc_out, pc_m); end
  endtask

  task automatic test_back_to_back();
    logic [4:0] done_seen, ready_seen;
    @(negedge clk);
    bus.req = 1'b1; bus.xfer_kind = 2'b00; bus.br_en = 1'b0; bus.imm = 32'h100; bus.rs1_out = '0;
    @(posedge clk);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      done_seen[i] = bus.done; ready_seen[i] = bus.ready;
    end
    bus.req = 1'b0;
    @(negedge clk);
    model_apply(2'b00, 1'b0, 32'h100, 32'h0, 1'b0);
    model_apply(2'b00, 1'b0, 32'h100, 32'h0, 1'b0);
    checks++; if (done_seen !== 5'b10010) begin errors++; $display("FAIL b2b_done: got %b exp 10010", done_seen); end
    checks++; if (ready_seen !== 5'b00100) begin errors++; $display("FAIL b2b_ready: got %b exp 00100", ready_seen); end
    checks++; if (bus.pc_out !== pc_m) begin errors++; $display("FAIL b2b_pc: got %h exp %h", bus.pc_out, pc_m); end
    checks++; if (bus.branch_cnt !== bcnt_m) begin errors++; $display("FAIL b2b_bcnt: got %h exp %h", bus.branch_cnt, bcnt_m); end
  endtask

  task automatic test_random();
    logic [1:0]  k;
    logic        b, clr, inc;
    logic [31:0] im, r, raw;
    int unsigned n;
    for (int it = 0; it < 40; it++) begin
      k = 2'($urandom); b = 1'($urandom); inc = 1'($urandom);
      clr = ($urandom_range(0, 9) == 0);
      raw = $urandom;
      im = {{20{raw[11]}}, raw[11:0]};
      r = $urandom;
      run_xfer(k, b, im, r, inc, clr);
      checks++; if ({o_ev_done, o_cm_done, o_cm_ready} !== 3'b010) begin errors++; $display("FAIL rnd_hs[%0d]: got %b exp 010", it, {o_ev_done, o_cm_done, o_cm_ready}); end
      checks++; if ({o_tk, o_ms} !== {exp_tk, exp_ms}) begin errors++; $display("FAIL rnd_flags[%0d]: got %b exp %b", it, {o_tk, o_ms}, {exp_tk, exp_ms}); end
      checks++; if (bus.pc_out !== pc_m) begin errors++; $display("FAIL rnd_pc[%0d]: got %h exp %h", it, bus.pc_out, pc_m); end
      checks++; if (bus.link_addr !== link_m) begin errors++; $display("FAIL rnd_link[%0d]: got %h exp %h", it, bus.link_addr, link_m); end
      checks++; if ({bus.branch_cnt, bus.taken_cnt} !== {bcnt_m, tcnt_m}) begin errors++; $display("FAIL rnd_cnt[%0d]: got %h/%h exp %h/%h", it, bus.branch_cnt, bus.taken_cnt, bcnt_m, tcnt_m); end
      n = $urandom_range(0, 2);
      if (n != 0) begin
        bus.pc_inc = 1'b1;
        repeat (n) @(posedge clk);
        @(negedge clk);
        bus.pc_inc = 1'b0;
        pc_m = pc_m + 4 * n;
        checks++; if (bus.pc_out !== pc_m) begin errors++; $display("FAIL rnd_inc[%0d]: got %h exp %h", it, bus.pc_out, pc_m); end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    checks = 0; errors = 0;
    bus.req = 1'b0; bus.xfer_kind = '0; bus.br_en = 1'b0; bus.imm = '0;
    bus.rs1_out = '0; bus.pc_inc = 1'b0; bus.stat_clr = 1'b0;
    rst = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_taken_beq();
    test_not_taken_inc();
    test_jalr();
    test_jal_wrap();
    test_simultaneous();
    test_saturate();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
